// File: rtl/dmem_arbiter_pkg.sv
// Shared memory-op encodings, arbiter state encodings and read-tag types for dmem_arbiter.
// Imported by the arbiter, its read-tag pipe and anything that talks to the data RAM.
package dmem_arbiter_pkg;

  localparam int MEM_OP_BITS = 2;

  localparam logic [MEM_OP_BITS-1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 2'd1;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 2'd2;

  localparam int ARB_STATE_BITS = 2;

  typedef enum logic [ARB_STATE_BITS-1:0] {
    ARB_IDLE     = 2'd0,
    ARB_CPU_RD   = 2'd1,
    ARB_DBG_SLOT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } rd_owner_e;

  // One entry per in-flight RAM read: who gets the data when it comes back.
  typedef struct packed {
    logic      valid;
    rd_owner_e owner;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_EMPTY = '{valid: 1'b0, owner: OWNER_CPU};

  // Encoding 2'b11 is unused; it is treated like NOP rather than forwarded to the RAM.
  function automatic logic is_mem_req(input logic [MEM_OP_BITS-1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

endpackage

// File: rtl/arb_rd_tag_pipe.sv
// Read-return tag pipeline: a DEPTH-stage shift register whose last stage lines up with
// the RAM read data, so the arbiter knows which port a returning word belongs to.
module arb_rd_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [DEPTH];

  // NOTE: this small array is reset on purpose -- a stale valid bit surviving reset would
  // produce a phantom dbg_rvalid or cpu return for a read the reset already cancelled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RD_TAG_EMPTY;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter between the pipeline MEM-stage cpu port and the debug loader port.
// The cpu has priority; a wait counter forces a debug slot after MAX_WAIT refusals.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MEM_OP_BITS-1:0] cpu_mem_op,
  input  logic [ADDR_W-1:0]      cpu_address,
  input  logic [DATA_W-1:0]      cpu_write_data,
  output logic [DATA_W-1:0]      cpu_read_data,
  output logic                   cpu_stall,
  input  logic                   dbg_req,
  input  logic                   dbg_we,
  input  logic [ADDR_W-1:0]      dbg_address,
  input  logic [DATA_W-1:0]      dbg_write_data,
  output logic                   dbg_gnt,
  output logic                   dbg_rvalid,
  output logic [DATA_W-1:0]      dbg_read_data,
  output logic [MEM_OP_BITS-1:0] ram_mem_op,
  output logic [ADDR_W-1:0]      ram_address,
  output logic [DATA_W-1:0]      ram_write_data,
  input  logic [DATA_W-1:0]      ram_read_data
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  rd_tag_t           tag_in, tag_out;

  logic cpu_req, cpu_is_read, cpu_rd_busy, force_dbg;
  logic cpu_win, dbg_win, cpu_ret, dbg_ret;

  // Arbitration. Reset gates both winners so every output reads 0 while reset is held.
  assign cpu_req     = is_mem_req(cpu_mem_op);
  assign cpu_is_read = (cpu_mem_op == MEM_OP_READ);
  assign cpu_rd_busy = (state_q == ARB_CPU_RD);
  assign force_dbg   = (state_q == ARB_DBG_SLOT) && dbg_req;
  assign cpu_win     = !reset && cpu_req && !cpu_rd_busy && !force_dbg;
  assign dbg_win     = !reset && dbg_req && !cpu_win;

  assign cpu_ret = tag_out.valid && (tag_out.owner == OWNER_CPU);
  assign dbg_ret = tag_out.valid && (tag_out.owner == OWNER_DBG);

  // During CPU_RD the held cpu request is the read already in flight, never a new one;
  // in the return cycle the stall drops so the pipeline advances with the data.
  assign cpu_stall = !reset && (cpu_rd_busy ? !cpu_ret
                                            : (cpu_req && (!cpu_win || cpu_is_read)));
  assign dbg_gnt   = dbg_win;

  // NOTE: every signal written here gets a default first, so no path through the block
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    ram_mem_op     = MEM_OP_NOP;
    ram_address    = '0;
    ram_write_data = '0;
    tag_in         = RD_TAG_EMPTY;
    if (cpu_win) begin
      ram_mem_op     = cpu_mem_op;
      ram_address    = cpu_address;
      ram_write_data = cpu_write_data;
      tag_in         = '{valid: cpu_is_read, owner: OWNER_CPU};
    end else if (dbg_win) begin
      ram_mem_op     = dbg_we ? MEM_OP_WRITE : MEM_OP_READ;
      ram_address    = dbg_address;
      ram_write_data = dbg_write_data;
      tag_in         = '{valid: !dbg_we, owner: OWNER_DBG};
    end
  end

  // Wait counter and next state.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    state_d    = ARB_IDLE;
    if (!dbg_req || dbg_win) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    if ((cpu_win && cpu_is_read) || (cpu_rd_busy && !cpu_ret)) begin
      state_d = ARB_CPU_RD;
    end else if (wait_cnt_d == WAIT_MAX) begin
      state_d = ARB_DBG_SLOT;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      wait_cnt_q  <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (cpu_ret) begin
        cpu_rdata_q <= ram_read_data;
      end
      if (dbg_ret) begin
        dbg_rdata_q <= ram_read_data;
      end
    end
  end

  // Return data is forwarded in its arrival cycle and held afterwards; each port only
  // ever sees words whose tag names it as owner.
  assign cpu_read_data = cpu_ret ? ram_read_data : cpu_rdata_q;
  assign dbg_read_data = dbg_ret ? ram_read_data : dbg_rdata_q;
  assign dbg_rvalid    = dbg_ret;

  arb_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3,
// driven by shared stimulus, each backed by its own behavioural RAM.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int                DATA_W   = 32;
  localparam int                ADDR_W   = 16;
  localparam int                MAX_WAIT = 8;
  localparam logic [DATA_W-1:0] NO_READ  = 32'hBAD0_0001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [MEM_OP_BITS-1:0] cpu_mem_op;
  logic [ADDR_W-1:0]      cpu_address;
  logic [DATA_W-1:0]      cpu_write_data;
  logic                   dbg_req;
  logic                   dbg_we;
  logic [ADDR_W-1:0]      dbg_address;
  logic [DATA_W-1:0]      dbg_write_data;

  logic [DATA_W-1:0]      cpu_read_data_1, dbg_read_data_1, ram_write_data_1, ram_read_data_1;
  logic                   cpu_stall_1, dbg_gnt_1, dbg_rvalid_1;
  logic [MEM_OP_BITS-1:0] ram_mem_op_1;
  logic [ADDR_W-1:0]      ram_address_1;

  logic [DATA_W-1:0]      cpu_read_data_3, dbg_read_data_3, ram_write_data_3, ram_read_data_3;
  logic                   cpu_stall_3, dbg_gnt_3, dbg_rvalid_3;
  logic [MEM_OP_BITS-1:0] ram_mem_op_3;
  logic [ADDR_W-1:0]      ram_address_3;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1), .MAX_WAIT(MAX_WAIT)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_mem_op(cpu_mem_op), .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data_1), .cpu_stall(cpu_stall_1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_address(dbg_address),
    .dbg_write_data(dbg_write_data), .dbg_gnt(dbg_gnt_1), .dbg_rvalid(dbg_rvalid_1),
    .dbg_read_data(dbg_read_data_1),
    .ram_mem_op(ram_mem_op_1), .ram_address(ram_address_1),
    .ram_write_data(ram_write_data_1), .ram_read_data(ram_read_data_1)
  );

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(3), .MAX_WAIT(MAX_WAIT)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_mem_op(cpu_mem_op), .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data_3), .cpu_stall(cpu_stall_3),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_address(dbg_address),
    .dbg_write_data(dbg_write_data), .dbg_gnt(dbg_gnt_3), .dbg_rvalid(dbg_rvalid_3),
    .dbg_read_data(dbg_read_data_3),
    .ram_mem_op(ram_mem_op_3), .ram_address(ram_address_3),
    .ram_write_data(ram_write_data_3), .ram_read_data(ram_read_data_3)
  );

  // Behavioural single-port RAMs: write at the edge, read data delayed by the latency.
  logic [DATA_W-1:0] mem_1 [65536];
  logic [DATA_W-1:0] mem_3 [65536];
  logic [DATA_W-1:0] rd_pipe_3 [3];

  always @(posedge clk) begin
    if (ram_mem_op_1 == MEM_OP_WRITE) mem_1[ram_address_1] <= ram_write_data_1;
    ram_read_data_1 <= (ram_mem_op_1 == MEM_OP_READ) ? mem_1[ram_address_1] : NO_READ;
  end

  always @(posedge clk) begin
    if (ram_mem_op_3 == MEM_OP_WRITE) mem_3[ram_address_3] <= ram_write_data_3;
    rd_pipe_3[0] <= (ram_mem_op_3 == MEM_OP_READ) ? mem_3[ram_address_3] : NO_READ;
    rd_pipe_3[1] <= rd_pipe_3[0];
    rd_pipe_3[2] <= rd_pipe_3[1];
  end
  assign ram_read_data_3 = rd_pipe_3[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [MEM_OP_BITS-1:0] op, input logic [15:0] ca,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic [15:0] da, input logic [31:0] dwd);
    cpu_mem_op     = op;
    cpu_address    = ca;
    cpu_write_data = cwd;
    dbg_req        = dreq;
    dbg_we         = dwe;
    dbg_address    = da;
    dbg_write_data = dwd;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(MEM_OP_NOP, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (n) advance();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rdata1"}, cpu_read_data_1, 0);
    check({tag, "_stall1"},     cpu_stall_1, 0);
    check({tag, "_gnt1"},       dbg_gnt_1, 0);
    check({tag, "_rvalid1"},    dbg_rvalid_1, 0);
    check({tag, "_dbg_rdata1"}, dbg_read_data_1, 0);
    check({tag, "_ram_op1"},    ram_mem_op_1, MEM_OP_NOP);
    check({tag, "_ram_addr1"},  ram_address_1, 0);
    check({tag, "_ram_wdata1"}, ram_write_data_1, 0);
    check({tag, "_cpu_rdata3"}, cpu_read_data_3, 0);
    check({tag, "_stall3"},     cpu_stall_3, 0);
    check({tag, "_gnt3"},       dbg_gnt_3, 0);
    check({tag, "_rvalid3"},    dbg_rvalid_3, 0);
    check({tag, "_dbg_rdata3"}, dbg_read_data_3, 0);
    check({tag, "_ram_op3"},    ram_mem_op_3, MEM_OP_NOP);
    check({tag, "_ram_addr3"},  ram_address_3, 0);
    check({tag, "_ram_wdata3"}, ram_write_data_3, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no summary by 100000 ns, expected run to complete");
    $fatal(1);
  end

  initial begin
    // Reset with live requests on both ports: outputs must stay 0.
    reset = 1'b1;
    drive(MEM_OP_READ, 16'h0010, 32'h0, 1'b1, 1'b0, 16'h0005, 32'h0);
    sample();
    check_reset_outputs("rst_hold");
    advance();

    // Debug read issued, then reset one cycle later: the read must never return.
    reset = 1'b0;
    drive(MEM_OP_NOP, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0005, 32'h0);
    sample();
    check("rst_pre_gnt1", dbg_gnt_1, 1);
    check("rst_pre_gnt3", dbg_gnt_3, 1);
    check("rst_pre_op1", ram_mem_op_1, MEM_OP_READ);
    check("rst_pre_addr1", ram_address_1, 32'h0005);
    advance();
    reset = 1'b1;
    drive(MEM_OP_READ, 16'h0010, 32'h0, 1'b1, 1'b0, 16'h0005, 32'h0);
    sample();
    check_reset_outputs("rst_mid");
    advance();
    reset = 1'b0;
    idle(0);
    for (int k = 0; k < 4; k++) begin
      sample();
      check($sformatf("rst_no_rvalid1_%0d", k), dbg_rvalid_1, 0);
      check($sformatf("rst_no_rvalid3_%0d", k), dbg_rvalid_3, 0);
      advance();
    end

    // First access after reset: debug write then read of the same word.
    drive(MEM_OP_NOP, 16'h0, 32'h0, 1'b1, 1'b1, 16'h0007, 32'hA5A5_A5A5);
    sample();
    check("post_wr_gnt1", dbg_gnt_1, 1);
    check("post_wr_op1", ram_mem_op_1, MEM_OP_WRITE);
    check("post_wr_wdata1", ram_write_data_1, 32'hA5A5_A5A5);
    advance();
    drive(MEM_OP_NOP, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0007, 32'h0);
    sample();
    check("post_rd_gnt1", dbg_gnt_1, 1);
    check("post_rd_gnt3", dbg_gnt_3, 1);
    advance();
    idle(0);
    for (int k = 1; k <= 3; k++) begin
      sample();
      check($sformatf("post_rvalid1_%0d", k), dbg_rvalid_1, (k == 1));
      check($sformatf("post_rvalid3_%0d", k), dbg_rvalid_3, (k == 3));
      if (k == 1) check("post_rdata1", dbg_read_data_1, 32'hA5A5_A5A5);
      if (k == 3) check("post_rdata3", dbg_read_data_3, 32'hA5A5_A5A5);
      advance();
    end
    idle(2);

    // Uncontended cpu write then read of 0x0010.
    drive(MEM_OP_WRITE, 16'h0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 16'h0, 32'h0);
    sample();
    check("cpu_wr_stall1", cpu_stall_1, 0);
    check("cpu_wr_stall3", cpu_stall_3, 0);
    check("cpu_wr_op1", ram_mem_op_1, MEM_OP_WRITE);
    check("cpu_wr_addr1", ram_address_1, 32'h0010);
    check("cpu_wr_wdata1", ram_write_data_1, 32'hDEAD_BEEF);
    advance();
    drive(MEM_OP_READ, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    sample();
    check("cpu_rd_stall1_n", cpu_stall_1, 1);
    check("cpu_rd_stall3_n", cpu_stall_3, 1);
    check("cpu_rd_op1", ram_mem_op_1, MEM_OP_READ);
    advance();
    sample();
    check("cpu_rd_stall1_n1", cpu_stall_1, 0);
    check("cpu_rd_data1", cpu_read_data_1, 32'hDEAD_BEEF);
    check("cpu_rd_noreissue1", ram_mem_op_1, MEM_OP_NOP);
    check("cpu_rd_stall3_n1", cpu_stall_3, 1);
    advance();
    idle(0);
    sample();
    check("cpu_rd_hold1", cpu_read_data_1, 32'hDEAD_BEEF);
    check("cpu_rd_stall3_n2", cpu_stall_3, 1);
    advance();
    sample();
    check("cpu_rd_stall3_n3", cpu_stall_3, 0);
    check("cpu_rd_data3", cpu_read_data_3, 32'hDEAD_BEEF);
    advance();
    idle(2);

    // Starvation bound: cpu writes every cycle, dbg_req held; 9th cycle goes to dbg.
    for (int i = 1; i <= 9; i++) begin
      drive(MEM_OP_WRITE, 16'(16'h0080 + i), 32'(32'h8000_0000 + i),
            1'b1, 1'b1, 16'h0030, 32'hCAFE_0030);
      sample();
      check($sformatf("starve_gnt1_%0d", i), dbg_gnt_1, (i == 9));
      check($sformatf("starve_gnt3_%0d", i), dbg_gnt_3, (i == 9));
      check($sformatf("starve_stall1_%0d", i), cpu_stall_1, (i == 9));
      if (i == 9) check("starve_addr1", ram_address_1, 32'h0030);
      advance();
    end
    drive(MEM_OP_WRITE, 16'h0089, 32'h8000_0009, 1'b0, 1'b0, 16'h0, 32'h0);
    sample();
    check("starve_done_stall1", cpu_stall_1, 0);
    check("starve_done_gnt1", dbg_gnt_1, 0);
    check("starve_done_op1", ram_mem_op_1, MEM_OP_WRITE);
    check("starve_done_addr1", ram_address_1, 32'h0089);
    advance();

    // Dropping dbg_req before a grant clears the wait counter.
    for (int i = 0; i < 15; i++) begin
      drive(MEM_OP_WRITE, 16'(16'h00A0 + i), 32'(i), (i != 5), 1'b1, 16'h0031, 32'hCAFE_0031);
      sample();
      check($sformatf("clr_gnt1_%0d", i), dbg_gnt_1, (i == 14));
      check($sformatf("clr_stall1_%0d", i), cpu_stall_1, (i == 14));
      advance();
    end
    drive(MEM_OP_WRITE, 16'h00AE, 32'd14, 1'b0, 1'b0, 16'h0, 32'h0);
    sample();
    check("clr_done_stall1", cpu_stall_1, 0);
    check("clr_done_addr1", ram_address_1, 32'h00AE);
    advance();
    idle(2);

    // Debug preload of 0x0..0x3 then dump, one grant per cycle, data in order.
    for (int i = 0; i < 4; i++) begin
      drive(MEM_OP_NOP, 16'h0, 32'h0, 1'b1, 1'b1, 16'(i), 32'(32'h1000_0000 + i));
      sample();
      check($sformatf("pre_gnt1_%0d", i), dbg_gnt_1, 1);
      check($sformatf("pre_gnt3_%0d", i), dbg_gnt_3, 1);
      check($sformatf("pre_op1_%0d", i), ram_mem_op_1, MEM_OP_WRITE);
      advance();
    end
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(MEM_OP_NOP, 16'h0, 32'h0, 1'b1, 1'b0, 16'(c), 32'h0);
      else       idle(0);
      sample();
      if (c < 4) check($sformatf("dump_gnt1_%0d", c), dbg_gnt_1, 1);
      check($sformatf("dump_rvalid1_%0d", c), dbg_rvalid_1, (c >= 1 && c <= 4));
      check($sformatf("dump_rvalid3_%0d", c), dbg_rvalid_3, (c >= 3 && c <= 6));
      if (c >= 1 && c <= 4)
        check($sformatf("dump_rdata1_%0d", c), dbg_read_data_1, 32'(32'h1000_0000 + c - 1));
      if (c >= 3 && c <= 6)
        check($sformatf("dump_rdata3_%0d", c), dbg_read_data_3, 32'(32'h1000_0000 + c - 3));
      advance();
    end
    idle(2);

    // Interleave on the RD_LAT=3 instance: cpu read in flight, dbg read issued behind it.
    drive(MEM_OP_WRITE, 16'h0050, 32'h55AA_55AA, 1'b0, 1'b0, 16'h0, 32'h0);
    sample();
    check("il_wr_stall3", cpu_stall_3, 0);
    advance();
    drive(MEM_OP_READ, 16'h0050, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    sample();
    check("il_n_stall3", cpu_stall_3, 1);
    check("il_n_op3", ram_mem_op_3, MEM_OP_READ);
    check("il_n_addr3", ram_address_3, 32'h0050);
    check("il_n_gnt3", dbg_gnt_3, 0);
    advance();
    drive(MEM_OP_READ, 16'h0050, 32'h0, 1'b1, 1'b0, 16'h0002, 32'h0);
    sample();
    check("il_n1_gnt3", dbg_gnt_3, 1);
    check("il_n1_stall3", cpu_stall_3, 1);
    check("il_n1_addr3", ram_address_3, 32'h0002);
    check("il_n1_op3", ram_mem_op_3, MEM_OP_READ);
    advance();
    drive(MEM_OP_READ, 16'h0050, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    sample();
    check("il_n2_stall3", cpu_stall_3, 1);
    check("il_n2_rvalid3", dbg_rvalid_3, 0);
    advance();
    sample();
    check("il_n3_stall3", cpu_stall_3, 0);
    check("il_n3_cpu_rdata3", cpu_read_data_3, 32'h55AA_55AA);
    check("il_n3_rvalid3", dbg_rvalid_3, 0);
    check("il_n3_dbg_rdata3", dbg_read_data_3, 32'h1000_0003);
    check("il_n3_noreissue3", ram_mem_op_3, MEM_OP_NOP);
    advance();
    idle(0);
    sample();
    check("il_n4_rvalid3", dbg_rvalid_3, 1);
    check("il_n4_dbg_rdata3", dbg_read_data_3, 32'h1000_0002);
    check("il_n4_cpu_rdata3", cpu_read_data_3, 32'h55AA_55AA);
    advance();
    idle(3);

    // Same address: dbg write granted, cpu read of that word the next cycle.
    drive(MEM_OP_NOP, 16'h0, 32'h0, 1'b1, 1'b1, 16'h0020, 32'h1234_5678);
    sample();
    check("same_gnt1", dbg_gnt_1, 1);
    check("same_gnt3", dbg_gnt_3, 1);
    advance();
    drive(MEM_OP_READ, 16'h0020, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    sample();
    check("same_stall1", cpu_stall_1, 1);
    check("same_stall3", cpu_stall_3, 1);
    advance();
    sample();
    check("same_stall1_n1", cpu_stall_1, 0);
    check("same_rdata1", cpu_read_data_1, 32'h1234_5678);
    advance();
    sample();
    check("same_stall3_n2", cpu_stall_3, 1);
    advance();
    sample();
    check("same_stall3_n3", cpu_stall_3, 0);
    check("same_rdata3", cpu_read_data_3, 32'h1234_5678);
    advance();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
